hub_slot_arb: RTL and testbench

Parametrised hub-slot sequencer. It generates the bus-enable strobe, the one-hot hub bus select and the free-running system counter for a configurable number of cogs. It sits between the cog array and the hub and replaces the fixed 8-cog round-robin. It adds a demand mode that grants the next hub slot only to an enabled, requesting cog, plus idle-slot accounting.

---
 rtl/hub_slot_arb_pkg.sv | 38 +++
 rtl/hub_slot_arb_rr_pick.sv | 34 +++
 rtl/hub_slot_arb.sv | 106 ++++++++++
 tb/tb_hub_slot_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_slot_arb_pkg.sv
// Shared types and helpers for the hub-slot sequencer.
package hub_arb_pkg;

  // Largest cog count any instance may be built with.
  localparam int MAX_COGS = 16;

  typedef enum logic {
    MODE_FIXED  = 1'b0,
    MODE_DEMAND = 1'b1
  } mode_e;

  // One-hot encoding of idx, limited to the low 'cogs' bits.
  function automatic logic [MAX_COGS-1:0] onehot(input logic [3:0] idx, input int cogs);
    logic [MAX_COGS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_COGS; i++) begin
      if (i < cogs && idx == 4'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Legacy rotation {sel[cogs-2:0], ~|sel[cogs-2:0]} on a 'cogs'-wide select.
  function automatic logic [MAX_COGS-1:0] rot_next(input logic [MAX_COGS-1:0] sel, input int cogs);
    logic [MAX_COGS-1:0] r;
    logic                any_low;
    r       = '0;
    any_low = 1'b0;
    for (int i = 0; i < MAX_COGS - 1; i++) begin
      if (i < cogs - 1) begin
        r[i+1]  = sel[i];
        any_low = any_low | sel[i];
      end
    end
    r[0] = ~any_low;
    return r;
  endfunction

endpackage

// File: rtl/hub_slot_arb_rr_pick.sv
// Rotating-priority encoder: first set bit of cand_i found by walking
// circularly upward from start_i.
module rr_pick #(
  parameter int COGS = 8
) (
  input  logic [COGS-1:0]         cand_i,
  input  logic [$clog2(COGS)-1:0] start_i,
  output logic                    found_o,
  output logic [$clog2(COGS)-1:0] idx_o
);

  localparam int SID_W = $clog2(COGS);

  // Scan all COGS positions starting at start_i; the first hit wins.
  always_comb begin
    int                j;
    logic              found;
    logic [SID_W-1:0]  idx;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < COGS; i++) begin
      j = int'(start_i) + i;
      if (j >= COGS) j = j - COGS;
      if (!found && cand_i[j]) begin
        found = 1'b1;
        idx   = SID_W'(j);
      end
    end
    found_o = found;
    idx_o   = idx;
  end

endmodule

// File: rtl/hub_slot_arb.sv
// Hub-slot sequencer: bus-enable strobe, one-hot hub owner and system
// counter, with fixed or demand-driven rotation and idle-slot accounting.
module hub_slot_arb
  import hub_arb_pkg::*;
#(
  parameter int COGS        = 8,
  parameter int SLOT_CYCLES = 2,
  parameter int CNT_W       = 32,
  parameter int IDLE_W      = 16
) (
  input  logic                    clk_cog,
  input  logic                    res,
  input  logic                    mode,
  input  logic [COGS-1:0]         cog_ena,
  input  logic [COGS-1:0]         req,
  output logic                    ena_bus,
  output logic [COGS-1:0]         bus_sel,
  output logic [$clog2(COGS)-1:0] slot_id,
  output logic                    grant_valid,
  output logic [CNT_W-1:0]        cnt,
  output logic [IDLE_W-1:0]       idle_slots
);

  localparam int SID_W = $clog2(COGS);
  localparam int PH_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [PH_W-1:0]   ph_q, ph_d;
  logic              ena_q, ena_d;
  logic [COGS-1:0]   bus_sel_q, bus_sel_d;
  logic [SID_W-1:0]  slot_q, slot_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [SID_W-1:0]  start;
  logic              pick_found;
  logic [SID_W-1:0]  pick_idx;

  // The search window begins one past the current owner and ends on it.
  assign start = (slot_q == SID_W'(COGS - 1)) ? '0 : slot_q + SID_W'(1);

  rr_pick #(
    .COGS (COGS)
  ) u_pick (
    .cand_i  (req & cog_ena),
    .start_i (start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Phase within the slot, the registered strobe for its last clock, and the system counter.
  always_comb begin
    ph_d  = (ph_q == PH_W'(SLOT_CYCLES - 1)) ? '0 : ph_q + PH_W'(1);
    ena_d = (ph_d == PH_W'(SLOT_CYCLES - 1));
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Owner selection; only an edge with the strobe high moves the owner or idle count.
  always_comb begin
    bus_sel_d = bus_sel_q;
    slot_d    = slot_q;
    idle_d    = idle_q;
    if (ena_q) begin
      if (mode == MODE_FIXED) begin
        slot_d    = start;
        bus_sel_d = COGS'(onehot(4'(start), COGS));
      end else if (pick_found) begin
        slot_d    = pick_idx;
        bus_sel_d = COGS'(onehot(4'(pick_idx), COGS));
      end else begin
        bus_sel_d = '0;
        if (idle_q != '1) idle_d = idle_q + IDLE_W'(1);
      end
    end
    grant_d = |bus_sel_d;
  end

  // State registers; reset clears any slot in progress immediately.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      ph_q      <= '0;
      ena_q     <= 1'b0;
      bus_sel_q <= '0;
      slot_q    <= SID_W'(COGS - 1);
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= '0;
    end else begin
      ph_q      <= ph_d;
      ena_q     <= ena_d;
      bus_sel_q <= bus_sel_d;
      slot_q    <= slot_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
    end
  end

  assign ena_bus     = ena_q;
  assign bus_sel     = bus_sel_q;
  assign slot_id     = slot_q;
  assign grant_valid = grant_q;
  assign cnt         = cnt_q;
  assign idle_slots  = idle_q;

endmodule

// File: tb/tb_hub_slot_arb.sv
// Bench for hub_slot_arb: two instances (8 cogs / 2-clock slots and
// 16 cogs / 3-clock slots with an 8-bit counter and 2-bit idle counter).
module tb_hub_slot_arb;
  import hub_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic res;

  // ---------------- instance A: 8 cogs, 2 clocks/slot ----------------
  logic        mode_a;
  logic [7:0]  ena_a, req_a;
  logic        ena_bus_a, grant_a;
  logic [7:0]  bus_sel_a;
  logic [2:0]  slot_id_a;
  logic [31:0] cnt_a;
  logic [15:0] idle_a;

  hub_slot_arb #(.COGS(8), .SLOT_CYCLES(2), .CNT_W(32), .IDLE_W(16)) u_dut_a (
    .clk_cog(clk), .res(res), .mode(mode_a), .cog_ena(ena_a), .req(req_a),
    .ena_bus(ena_bus_a), .bus_sel(bus_sel_a), .slot_id(slot_id_a),
    .grant_valid(grant_a), .cnt(cnt_a), .idle_slots(idle_a)
  );

  // ---------------- instance B: 16 cogs, 3 clocks/slot ----------------
  logic        mode_b;
  logic [15:0] ena_b, req_b;
  logic        ena_bus_b, grant_b;
  logic [15:0] bus_sel_b;
  logic [3:0]  slot_id_b;
  logic [7:0]  cnt_b;
  logic [1:0]  idle_b;

  hub_slot_arb #(.COGS(16), .SLOT_CYCLES(3), .CNT_W(8), .IDLE_W(2)) u_dut_b (
    .clk_cog(clk), .res(res), .mode(mode_b), .cog_ena(ena_b), .req(req_b),
    .ena_bus(ena_bus_b), .bus_sel(bus_sel_b), .slot_id(slot_id_b),
    .grant_valid(grant_b), .cnt(cnt_b), .idle_slots(idle_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // State is "clocks since reset", current owner, whether a grant is live, idle count.
  typedef struct {
    int c;
    int owner;
    bit valid;
    int idle;
  } mstate_t;

  mstate_t ma, mb;

  function automatic bit m_ena(input int c, input int sc);
    return (c > 0) && ((c % sc) == sc - 1);
  endfunction

  function automatic mstate_t m_reset(input int cogs);
    mstate_t s;
    s.c = 0; s.owner = cogs - 1; s.valid = 1'b0; s.idle = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input logic mode, input logic [15:0] en,
                                     input logic [15:0] rq, input int cogs, input int sc,
                                     input int idle_max);
    mstate_t n;
    int      j;
    n = s;
    j = 0;
    if (m_ena(s.c, sc)) begin
      if (mode == 1'b0) begin
        n.owner = (s.owner + 1) % cogs;
        n.valid = 1'b1;
      end else begin
        n.valid = 1'b0;
        for (int k = 1; k <= cogs; k++) begin
          j = (s.owner + k) % cogs;
          if (!n.valid && en[j] && rq[j]) begin
            n.owner = j;
            n.valid = 1'b1;
          end
        end
        if (!n.valid && s.idle < idle_max) n.idle = s.idle + 1;
      end
    end
    n.c = s.c + 1;
    return n;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      ma <= m_reset(8);
      mb <= m_reset(16);
    end else begin
      ma <= m_step(ma, mode_a, {8'h00, ena_a}, {8'h00, req_a}, 8, 2, 65535);
      mb <= m_step(mb, mode_b, ena_b, req_b, 16, 3, 3);
    end
  end

  task automatic check_model();
    chk("m_ena_a",   ena_bus_a, 32'(m_ena(ma.c, 2)));
    chk("m_sel_a",   bus_sel_a, ma.valid ? (32'd1 << ma.owner) : 32'd0);
    chk("m_slot_a",  slot_id_a, ma.owner);
    chk("m_grant_a", grant_a,   32'(ma.valid));
    chk("m_cnt_a",   cnt_a,     ma.c);
    chk("m_idle_a",  idle_a,    ma.idle);
    chk("m_ena_b",   ena_bus_b, 32'(m_ena(mb.c, 3)));
    chk("m_sel_b",   bus_sel_b, mb.valid ? (32'd1 << mb.owner) : 32'd0);
    chk("m_slot_b",  slot_id_b, mb.owner);
    chk("m_grant_b", grant_b,   32'(mb.valid));
    chk("m_cnt_b",   cnt_b,     mb.c % 256);
    chk("m_idle_b",  idle_b,    mb.idle);
  endtask

  // ---------------- driver helpers ----------------
  // Return at the falling edge just after the next slot boundary of A.
  task automatic wait_bnd_a();
    int guard = 0;
    while (ena_bus_a !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("bnd_a_timeout", 32'(guard < 10), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_bnd_b();
    int guard = 0;
    while (ena_bus_b !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("bnd_b_timeout", 32'(guard < 10), 32'd1);
    @(negedge clk);
  endtask

  // ---------------- directed vector table for A ----------------
  typedef struct {
    logic        mode;
    logic [7:0]  ena;
    logic [7:0]  req;
    logic [7:0]  exp_sel;
    logic [2:0]  exp_id;
    logic [15:0] exp_idle;
  } row_t;

  row_t tbl[15];

  initial begin
    logic [15:0] leg;
    logic [15:0] e;
    int          nb, prev_nb;

    tbl[0]  = '{1'b1, 8'hFF, 8'h24, 8'h04, 3'd2, 16'd0};
    tbl[1]  = '{1'b1, 8'hFF, 8'h24, 8'h20, 3'd5, 16'd0};
    tbl[2]  = '{1'b1, 8'hFF, 8'h24, 8'h04, 3'd2, 16'd0};
    tbl[3]  = '{1'b1, 8'hFF, 8'h24, 8'h20, 3'd5, 16'd0};
    tbl[4]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd5, 16'd1};
    tbl[5]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd5, 16'd2};
    tbl[6]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd5, 16'd3};
    tbl[7]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd5, 16'd4};
    tbl[8]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd5, 16'd5};
    tbl[9]  = '{1'b1, 8'h7F, 8'h80, 8'h00, 3'd5, 16'd6};
    tbl[10] = '{1'b0, 8'h7F, 8'h80, 8'h40, 3'd6, 16'd6};
    tbl[11] = '{1'b1, 8'hFF, 8'h08, 8'h08, 3'd3, 16'd6};
    tbl[12] = '{1'b1, 8'hFF, 8'h08, 8'h08, 3'd3, 16'd6};
    tbl[13] = '{1'b1, 8'h01, 8'h09, 8'h01, 3'd0, 16'd6};
    tbl[14] = '{1'b0, 8'hFF, 8'hFF, 8'h02, 3'd1, 16'd6};

    // Reset held over a few clocks.
    res    = 1'b1;
    mode_a = 1'b0; ena_a = 8'hFF;    req_a = 8'h00;
    mode_b = 1'b0; ena_b = 16'hFFFF; req_b = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ena_a",  ena_bus_a, 0);
    chk("rst_sel_a",  bus_sel_a, 0);
    chk("rst_slot_a", slot_id_a, 7);
    chk("rst_gnt_a",  grant_a,   0);
    chk("rst_cnt_a",  cnt_a,     0);
    chk("rst_idle_a", idle_a,    0);
    chk("rst_slot_b", slot_id_b, 15);
    chk("rst_sel_b",  bus_sel_b, 0);
    res = 1'b0;

    // Fixed rotation on both instances, checked against closed-form expectations.
    leg     = '0;
    prev_nb = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      nb = cyc / 2;
      e  = (nb > 0) ? (16'd1 << ((nb - 1) % 8)) : 16'd0;
      if (nb != prev_nb) leg = rot_next(leg, 8);
      prev_nb = nb;
      chk("fix_ena_a", ena_bus_a, 32'((cyc % 2) == 1));
      chk("fix_sel_a", bus_sel_a, e);
      chk("fix_leg_a", bus_sel_a, leg[7:0]);
      chk("fix_cnt_a", cnt_a, cyc);
      nb = cyc / 3;
      e  = (nb > 0) ? (16'd1 << ((nb - 1) % 16)) : 16'd0;
      chk("fix_ena_b", ena_bus_b, 32'((cyc % 3) == 2));
      chk("fix_sel_b", bus_sel_b, e);
      chk("fix_cnt_b", cnt_b, cyc % 256);
      check_model();
    end

    // Directed demand/fixed vectors, one row per slot boundary.
    for (int r = 0; r < 15; r++) begin
      mode_a = tbl[r].mode;
      ena_a  = tbl[r].ena;
      req_a  = tbl[r].req;
      wait_bnd_a();
      chk($sformatf("tbl%0d_sel", r),  bus_sel_a, tbl[r].exp_sel);
      chk($sformatf("tbl%0d_id", r),   slot_id_a, tbl[r].exp_id);
      chk($sformatf("tbl%0d_gnt", r),  grant_a,   32'(|tbl[r].exp_sel));
      chk($sformatf("tbl%0d_idle", r), idle_a,    tbl[r].exp_idle);
      check_model();
    end

    // Asynchronous reset in the first clock of cog 3's slot.
    wait_bnd_a();
    wait_bnd_a();
    chk("pre_rst_sel", bus_sel_a, 8'h08);
    #2;
    res    = 1'b1;
    mode_b = 1'b1;
    req_b  = 16'h0000;
    #1;
    chk("arst_sel_a",  bus_sel_a, 0);
    chk("arst_ena_a",  ena_bus_a, 0);
    chk("arst_cnt_a",  cnt_a,     0);
    chk("arst_slot_a", slot_id_a, 7);
    chk("arst_gnt_a",  grant_a,   0);
    chk("arst_idle_a", idle_a,    0);
    check_model();
    @(negedge clk);
    res = 1'b0;
    wait_bnd_a();
    chk("post_rst_sel", bus_sel_a, 8'h01);
    chk("post_rst_id",  slot_id_a, 0);

    // Idle saturation on the 2-bit counter of B.
    for (int k = 1; k <= 5; k++) begin
      wait_bnd_b();
      chk($sformatf("sat%0d_idle", k), idle_b, (k < 3) ? k : 3);
      chk($sformatf("sat%0d_sel", k),  bus_sel_b, 0);
      chk($sformatf("sat%0d_slot", k), slot_id_b, 15);
      check_model();
    end

    // Randomised traffic against the reference model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check_model();
      if ($urandom_range(0, 7) == 0) mode_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) mode_b = 1'($urandom_range(0, 1));
      ena_a = 8'($urandom) | 8'($urandom);
      req_a = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
      ena_b = 16'($urandom) | 16'($urandom);
      req_b = ($urandom_range(0, 3) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
    end
    @(negedge clk);
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
